mem_ctrl: RTL and testbench
===========================

Name: mem_ctrl

Overview:
- Memory controller sitting between the byte-wide unified RAM/IO port and its two initiators: instruction fetch and the load/store buffer.
- Serves each request as a byte-serial sequence of 1, 2 or 4 bytes and returns a one-cycle done pulse.
- Arbitrates the two initiators, honours rollback and throttles IO writes on io_buffer_full.

Parameters:
- ADDR_W, 32, address width of mem_a, if_pc and lsb_addr.
- IO_MASK_HI, 17, IO space is any address with bits [IO_MASK_HI:IO_MASK_HI-1] == 2'b11.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- rdy  in  1  global ready; low freezes all state
- rollback  in  1  branch-mispredict flush
- mem_din  in  8  RAM read byte, valid the cycle after the address is sampled
- mem_dout  out  8  RAM write byte
- mem_a  out  ADDR_W  RAM byte address
- mem_wr  out  1  1 = write, 0 = read
- io_buffer_full  in  1  IO write buffer full
- if_en  in  1  fetch request; held until if_done
- if_pc  in  ADDR_W  fetch address (always 4 bytes)
- if_done  out  1  one-cycle fetch completion pulse
- if_data  out  32  fetched word, little-endian
- lsb_en  in  1  load/store request; held until lsb_done
- lsb_wr  in  1  1 = store, 0 = load
- lsb_addr  in  ADDR_W  access address
- lsb_size  in  2  0 = byte, 1 = half, 2 = word; 3 is illegal and treated as word
- lsb_w_data  in  32  store data; low N bytes are used
- lsb_done  out  1  one-cycle load/store completion pulse
- lsb_r_data  out  32  load data, zero-extended; the LSB performs sign extension

Behaviour:
- Reset (async, rst=1): state=IDLE; mem_a, mem_dout, mem_wr, if_done, lsb_done, if_data, lsb_r_data all 0; byte counter 0.
- rdy=0: every register holds, outputs included.
- States: IDLE, READ, WRITE. A source flag (IF/LSB) records the owner.
- Handshake:
  - Requesters hold en and operands stable until their done pulse.
  - Each done pulse is high for exactly one cycle.
  - In any cycle where if_done or lsb_done is high, both en inputs are ignored (requester drops en at that edge).
- Arbitration in IDLE, when not ignoring and no rollback:
  - lsb_en wins over if_en.
  - if_en is served only when lsb_en=0.
- READ, N bytes (N=4 for fetch):
  - Acceptance edge E0: mem_a=addr, mem_wr=0.
  - Edge Ek, k=1..N-1: mem_a=addr+k.
  - Edge E(k+2): mem_din captured into byte k of the result.
  - Edge E(N+1): last byte captured, done=1, data valid, state=IDLE.
  - Word read latency: done visible 5 cycles after acceptance.
- WRITE, N bytes:
  - Edge Ek, k=0..N-1: mem_a=addr+k, mem_dout=w_data[8k+7:8k], mem_wr=1.
  - Edge EN: mem_wr=0, lsb_done=1, state=IDLE.
- IO throttle:
  - A store to IO space is not accepted while io_buffer_full=1; it stays pending in IDLE and fetch is not served in its place.
  - IO accesses are byte-sized; the bench never issues wider ones.
- Rollback, sampled at an edge:
  - IDLE: no request is accepted at that edge.
  - READ (either source): abort to IDLE, no done pulse, including when this edge would have raised done.
  - WRITE: unaffected; the store is already committed and completes with lsb_done.
- mem_wr is 0 in every cycle not in WRITE.
- Addresses increment modulo 2^ADDR_W; no wrap special case.
- lsb_r_data bytes above N are 0.

Test Plan:
- Fetch: if_en=1, if_pc=0x100, RAM[0x100..0x103]=13,05,A0,00 → mem_a 0x100..0x103 on consecutive cycles; if_done pulses once, 5 cycles after acceptance, with if_data=0x00A00513.
- Half load: lsb_size=1, addr=0x202, RAM=FE,FF → lsb_r_data=0x0000FFFE, single lsb_done, mem_wr stays 0.
- Word store: lsb_wr=1, addr=0x300, data=0xDEADBEEF → mem_wr=1 for 4 cycles writing EF,BE,AD,DE at 0x300..0x303; lsb_done on the 5th edge.
- Contention plus rollback:
  - if_en and lsb_en raised together → load served first.
  - Rollback asserted 2 cycles into the following fetch → fetch aborts with no if_done and returns to IDLE.
  - Rollback asserted during a store → the store still completes with lsb_done.
- IO: byte store to 0x30000 with io_buffer_full=1 for 3 cycles → no mem_wr until full drops, then one write of the data byte and lsb_done.
- Reset mid-READ: assert rst asynchronously → all outputs 0 immediately, without waiting for a clock edge; after release the next if_en completes normally.

Source files
------------

// File: rtl/mem_ctrl.sv
// mem_ctrl: byte-serial memory controller that arbitrates instruction fetch and the
// load/store buffer onto the shared byte-wide RAM/IO port.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   rdy                 global ready; low freezes every register
//   rollback            mispredict flush; aborts reads, never stores
//   mem_din/dout/a/wr   byte-wide RAM/IO port (read data arrives one cycle after address)
//   io_buffer_full      stalls acceptance of stores into IO space
//   if_en/pc/done/data  fetch initiator, always 4 bytes
//   lsb_*               load/store initiator, 1/2/4 bytes, loads zero-extended
module mem_ctrl #(
    parameter int ADDR_W     = 32,
    parameter int IO_MASK_HI = 17
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              rollback,
    input  logic [7:0]        mem_din,
    output logic [7:0]        mem_dout,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_wr,
    input  logic              io_buffer_full,
    input  logic              if_en,
    input  logic [ADDR_W-1:0] if_pc,
    output logic              if_done,
    output logic [31:0]       if_data,
    input  logic              lsb_en,
    input  logic              lsb_wr,
    input  logic [ADDR_W-1:0] lsb_addr,
    input  logic [1:0]        lsb_size,
    input  logic [31:0]       lsb_w_data,
    output logic              lsb_done,
    output logic [31:0]       lsb_r_data
);
    typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

    state_t            state_q;
    logic              src_lsb_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_k;
    logic [31:0]       wdata_q;
    logic [31:0]       buf_q;
    logic [31:0]       rd_word;
    logic [2:0]        cnt_q;
    logic [2:0]        n_q;
    logic [2:0]        lsb_n;
    logic [1:0]        byte_idx;
    logic              io_block;
    logic              take_lsb;
    logic              take_if;

    always_comb begin
        lsb_n    = lsb_size == 2'd0 ? 3'd1 : lsb_size == 2'd1 ? 3'd2 : 3'd4;
        // a blocked IO store keeps lsb_en high, which also keeps fetch out
        io_block = lsb_en && lsb_wr && lsb_addr[IO_MASK_HI -: 2] == 2'b11 && io_buffer_full;
        take_lsb = !if_done && !lsb_done && !rollback && lsb_en && !io_block;
        take_if  = !if_done && !lsb_done && !rollback && if_en && !lsb_en;
        addr_k   = addr_q + ADDR_W'(cnt_q);
        // byte arriving at edge k+2 belongs to address k
        byte_idx = cnt_q[1:0] - 2'd2;
        rd_word  = buf_q;
        rd_word[{byte_idx, 3'b000} +: 8] = mem_din;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            src_lsb_q  <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            buf_q      <= '0;
            cnt_q      <= '0;
            n_q        <= '0;
            mem_a      <= '0;
            mem_dout   <= '0;
            mem_wr     <= 1'b0;
            if_done    <= 1'b0;
            lsb_done   <= 1'b0;
            if_data    <= '0;
            lsb_r_data <= '0;
        end else if (rdy) begin
            if_done  <= 1'b0;
            lsb_done <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (take_lsb) begin
                        src_lsb_q <= 1'b1;
                        addr_q    <= lsb_addr;
                        wdata_q   <= lsb_w_data;
                        n_q       <= lsb_n;
                        cnt_q     <= 3'd1;
                        buf_q     <= '0;
                        mem_a     <= lsb_addr;
                        mem_wr    <= lsb_wr;
                        mem_dout  <= lsb_wr ? lsb_w_data[7:0] : mem_dout;
                        state_q   <= lsb_wr ? WRITE : READ;
                    end else if (take_if) begin
                        src_lsb_q <= 1'b0;
                        addr_q    <= if_pc;
                        n_q       <= 3'd4;
                        cnt_q     <= 3'd1;
                        buf_q     <= '0;
                        mem_a     <= if_pc;
                        mem_wr    <= 1'b0;
                        state_q   <= READ;
                    end
                end
                READ: begin
                    if (rollback) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else begin
                        if (cnt_q < n_q)
                            mem_a <= addr_k;
                        if (cnt_q == n_q + 3'd1) begin
                            state_q <= IDLE;
                            cnt_q   <= '0;
                            if (src_lsb_q) begin
                                lsb_done   <= 1'b1;
                                lsb_r_data <= rd_word;
                            end else begin
                                if_done <= 1'b1;
                                if_data <= rd_word;
                            end
                        end else begin
                            cnt_q <= cnt_q + 3'd1;
                            if (cnt_q >= 3'd2)
                                buf_q <= rd_word;
                        end
                    end
                end
                WRITE: begin
                    // stores are committed once accepted, so rollback is ignored here
                    if (cnt_q < n_q) begin
                        mem_a    <= addr_k;
                        mem_dout <= wdata_q[{cnt_q[1:0], 3'b000} +: 8];
                        cnt_q    <= cnt_q + 3'd1;
                    end else begin
                        mem_wr   <= 1'b0;
                        lsb_done <= 1'b1;
                        cnt_q    <= '0;
                        state_q  <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: randomized self-checking bench for mem_ctrl with a byte RAM model and
// a word-level reference computed from RAM contents.
module tb_mem_ctrl;
    logic        clk;
    logic        rst;
    logic        rdy;
    logic        rollback;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        io_buffer_full;
    logic        if_en;
    logic [31:0] if_pc;
    logic        if_done;
    logic [31:0] if_data;
    logic        lsb_en;
    logic        lsb_wr;
    logic [31:0] lsb_addr;
    logic [1:0]  lsb_size;
    logic [31:0] lsb_w_data;
    logic        lsb_done;
    logic [31:0] lsb_r_data;

    int checks = 0;
    int errors = 0;
    int wr_cnt = 0;
    logic [7:0] ram [logic [31:0]];

    mem_ctrl #(.ADDR_W(32), .IO_MASK_HI(17)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        .io_buffer_full(io_buffer_full),
        .if_en(if_en), .if_pc(if_pc), .if_done(if_done), .if_data(if_data),
        .lsb_en(lsb_en), .lsb_wr(lsb_wr), .lsb_addr(lsb_addr), .lsb_size(lsb_size),
        .lsb_w_data(lsb_w_data), .lsb_done(lsb_done), .lsb_r_data(lsb_r_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] ram_byte(input logic [31:0] a);
        if (ram.exists(a)) return ram[a];
        return a[7:0] ^ a[15:8] ^ 8'h3C;
    endfunction

    // little-endian word of n bytes starting at a, upper bytes zero
    function automatic logic [31:0] exp_word(input logic [31:0] a, input int n);
        logic [31:0] r = '0;
        for (int i = 0; i < n; i++) r[8*i +: 8] = ram_byte(a + 32'(i));
        return r;
    endfunction

    // RAM: registers address each active cycle, data valid the following cycle
    always @(posedge clk) begin
        if (rdy) begin
            if (mem_wr) begin
                ram[mem_a] = mem_dout;
                wr_cnt++;
            end
            mem_din <= ram_byte(mem_a);
        end
    end

    task automatic test_reset;
        #1;
        checks++;
        if ({mem_a, mem_dout, mem_wr, if_done, lsb_done, if_data, lsb_r_data} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: mem_a=%h dout=%h wr=%b ifd=%b lsd=%b if_data=%h r_data=%h expected all 0",
                     mem_a, mem_dout, mem_wr, if_done, lsb_done, if_data, lsb_r_data);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_fetch;
        int cyc = 0;
        bit got = 0;
        bit wr_seen = 0;
        ram[32'h100] = 8'h13; ram[32'h101] = 8'h05; ram[32'h102] = 8'hA0; ram[32'h103] = 8'h00;
        if_pc = 32'h100;
        if_en = 1'b1;
        while (!got && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (mem_wr) wr_seen = 1;
            if (cyc <= 4) begin
                checks++;
                if (mem_a !== 32'h100 + 32'(cyc - 1)) begin
                    errors++;
                    $display("FAIL fetch_addr%0d: mem_a=%h expected %h", cyc - 1, mem_a, 32'h100 + 32'(cyc - 1));
                end
            end
            got = if_done;
        end
        if_en = 1'b0;
        checks++;
        if (!got || cyc != 6) begin
            errors++;
            $display("FAIL fetch_latency: done=%b at cycle %0d expected cycle 6", got, cyc);
        end
        checks++;
        if (if_data !== 32'h00A00513) begin
            errors++;
            $display("FAIL fetch_data: if_data=%h expected 00a00513", if_data);
        end
        @(negedge clk);
        checks++;
        if (if_done !== 1'b0 || wr_seen) begin
            errors++;
            $display("FAIL fetch_pulse: if_done=%b wr_seen=%b expected 0 0", if_done, wr_seen);
        end
    endtask

    task automatic test_half_load;
        int cyc = 0;
        bit got = 0;
        bit wr_seen = 0;
        ram[32'h202] = 8'hFE; ram[32'h203] = 8'hFF;
        lsb_en = 1'b1; lsb_wr = 1'b0; lsb_addr = 32'h202; lsb_size = 2'd1;
        while (!got && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (mem_wr) wr_seen = 1;
            got = lsb_done;
        end
        lsb_en = 1'b0;
        checks++;
        if (!got || cyc != 4) begin
            errors++;
            $display("FAIL half_latency: done=%b at cycle %0d expected cycle 4", got, cyc);
        end
        checks++;
        if (lsb_r_data !== 32'h0000FFFE) begin
            errors++;
            $display("FAIL half_data: lsb_r_data=%h expected 0000fffe", lsb_r_data);
        end
        @(negedge clk);
        checks++;
        if (lsb_done !== 1'b0 || wr_seen) begin
            errors++;
            $display("FAIL half_pulse: lsb_done=%b wr_seen=%b expected 0 0", lsb_done, wr_seen);
        end
    endtask

    task automatic test_word_store;
        int cyc = 0;
        bit got = 0;
        logic [31:0] d = 32'hDEADBEEF;
        lsb_en = 1'b1; lsb_wr = 1'b1; lsb_addr = 32'h300; lsb_size = 2'd2; lsb_w_data = d;
        while (!got && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (cyc <= 4) begin
                checks++;
                if ({mem_wr, mem_a, mem_dout} !== {1'b1, 32'h300 + 32'(cyc - 1), d[8*(cyc-1) +: 8]}) begin
                    errors++;
                    $display("FAIL store_byte%0d: wr=%b a=%h dout=%h expected 1 %h %h",
                             cyc - 1, mem_wr, mem_a, mem_dout, 32'h300 + 32'(cyc - 1), d[8*(cyc-1) +: 8]);
                end
            end
            got = lsb_done;
        end
        lsb_en = 1'b0; lsb_wr = 1'b0;
        checks++;
        if (!got || cyc != 5 || mem_wr !== 1'b0) begin
            errors++;
            $display("FAIL store_done: done=%b cycle %0d wr=%b expected cycle 5 wr 0", got, cyc, mem_wr);
        end
        checks++;
        if (exp_word(32'h300, 4) !== d) begin
            errors++;
            $display("FAIL store_ram: ram=%h expected %h", exp_word(32'h300, 4), d);
        end
        @(negedge clk);
    endtask

    task automatic test_contention_rollback;
        int cyc = 0;
        bit got = 0;
        bit if_seen = 0;
        logic [31:0] ld = $urandom_range(32'h500, 32'h5FC);
        logic [31:0] exp = exp_word(ld, 4);
        logic [31:0] sd = $urandom;
        lsb_en = 1'b1; lsb_wr = 1'b0; lsb_size = 2'd2; lsb_addr = ld;
        if_en = 1'b1; if_pc = 32'h600;
        while (!got && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (if_done) if_seen = 1;
            got = lsb_done;
        end
        lsb_en = 1'b0;
        checks++;
        if (!got || cyc != 6 || if_seen) begin
            errors++;
            $display("FAIL arb_load_first: done=%b cycle %0d if_seen=%b expected cycle 6 no fetch", got, cyc, if_seen);
        end
        checks++;
        if (lsb_r_data !== exp) begin
            errors++;
            $display("FAIL arb_load_data: lsb_r_data=%h expected %h", lsb_r_data, exp);
        end
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (mem_a !== 32'h600) begin
            errors++;
            $display("FAIL arb_fetch_start: mem_a=%h expected 00000600", mem_a);
        end
        @(negedge clk);
        rollback = 1'b1;
        @(negedge clk);
        rollback = 1'b0;
        if_en = 1'b0;
        if_seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (if_done) if_seen = 1;
        end
        checks++;
        if (if_seen) begin
            errors++;
            $display("FAIL rollback_read: if_done=1 expected no pulse after abort");
        end
        lsb_en = 1'b1; lsb_wr = 1'b1; lsb_size = 2'd2; lsb_addr = 32'h700; lsb_w_data = sd;
        cyc = 0; got = 0;
        while (!got && cyc < 20) begin
            @(negedge clk);
            cyc++;
            rollback = (cyc == 2);
            got = lsb_done;
        end
        rollback = 1'b0;
        lsb_en = 1'b0; lsb_wr = 1'b0;
        checks++;
        if (!got || cyc != 5 || exp_word(32'h700, 4) !== sd) begin
            errors++;
            $display("FAIL rollback_store: done=%b cycle %0d ram=%h expected cycle 5 ram %h",
                     got, cyc, exp_word(32'h700, 4), sd);
        end
        @(negedge clk);
    endtask

    task automatic test_io;
        int cyc = 0;
        bit got = 0;
        int w0 = wr_cnt;
        logic [7:0] b = 8'($urandom);
        logic [31:0] exp = exp_word(32'h400, 4);
        lsb_en = 1'b1; lsb_wr = 1'b1; lsb_size = 2'd0; lsb_addr = 32'h30000; lsb_w_data = {24'h0, b};
        if_en = 1'b1; if_pc = 32'h400;
        io_buffer_full = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (mem_wr !== 1'b0 || lsb_done !== 1'b0 || if_done !== 1'b0 || mem_a === 32'h400) begin
                errors++;
                $display("FAIL io_stall%0d: wr=%b lsd=%b ifd=%b a=%h expected idle, no fetch", i, mem_wr, lsb_done, if_done, mem_a);
            end
        end
        io_buffer_full = 1'b0;
        @(negedge clk);
        checks++;
        if ({mem_wr, mem_a, mem_dout} !== {1'b1, 32'h30000, b}) begin
            errors++;
            $display("FAIL io_write: wr=%b a=%h dout=%h expected 1 00030000 %h", mem_wr, mem_a, mem_dout, b);
        end
        @(negedge clk);
        checks++;
        if (lsb_done !== 1'b1 || mem_wr !== 1'b0) begin
            errors++;
            $display("FAIL io_done: lsb_done=%b wr=%b expected 1 0", lsb_done, mem_wr);
        end
        lsb_en = 1'b0; lsb_wr = 1'b0;
        while (!got && cyc < 20) begin
            @(negedge clk);
            cyc++;
            got = if_done;
        end
        if_en = 1'b0;
        checks++;
        if (!got || if_data !== exp) begin
            errors++;
            $display("FAIL io_then_fetch: done=%b if_data=%h expected %h", got, if_data, exp);
        end
        checks++;
        if (wr_cnt - w0 != 1 || ram_byte(32'h30000) !== b) begin
            errors++;
            $display("FAIL io_single_write: writes=%0d byte=%h expected 1 %h", wr_cnt - w0, ram_byte(32'h30000), b);
        end
        @(negedge clk);
    endtask

    task automatic test_rdy;
        int cyc = 0;
        bit got = 0;
        logic [31:0] a;
        logic [31:0] exp = exp_word(32'h800, 4);
        lsb_en = 1'b1; lsb_wr = 1'b0; lsb_size = 2'd2; lsb_addr = 32'h800;
        @(negedge clk);
        @(negedge clk);
        rdy = 1'b0;
        a = mem_a;
        for (int i = 0; i < 3; i++) @(negedge clk);
        checks++;
        if (mem_a !== a || a !== 32'h801 || lsb_done !== 1'b0) begin
            errors++;
            $display("FAIL rdy_freeze: mem_a=%h done=%b expected 00000801 0", mem_a, lsb_done);
        end
        rdy = 1'b1;
        while (!got && cyc < 20) begin
            @(negedge clk);
            cyc++;
            got = lsb_done;
        end
        lsb_en = 1'b0;
        checks++;
        if (!got || cyc != 4 || lsb_r_data !== exp) begin
            errors++;
            $display("FAIL rdy_resume: done=%b cycle %0d data=%h expected cycle 4 %h", got, cyc, lsb_r_data, exp);
        end
        @(negedge clk);
    endtask

    task automatic test_wrap;
        int cyc = 0;
        bit got = 0;
        logic [31:0] exp = exp_word(32'hFFFF_FFFE, 4);
        if_en = 1'b1; if_pc = 32'hFFFF_FFFE;
        while (!got && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (cyc == 3 || cyc == 4) begin
                checks++;
                if (mem_a !== 32'(cyc - 3)) begin
                    errors++;
                    $display("FAIL wrap_addr: mem_a=%h expected %h", mem_a, 32'(cyc - 3));
                end
            end
            got = if_done;
        end
        if_en = 1'b0;
        checks++;
        if (!got || if_data !== exp) begin
            errors++;
            $display("FAIL wrap_data: done=%b if_data=%h expected %h", got, if_data, exp);
        end
        @(negedge clk);
    endtask

    task automatic test_random;
        for (int t = 0; t < 40; t++) begin
            int kind = $urandom_range(0, 2);
            logic [31:0] addr = $urandom_range(0, 32'hFFF);
            logic [1:0] size = 2'($urandom_range(0, 3));
            logic [31:0] data = $urandom;
            int n = kind == 0 ? 4 : size >= 2 ? 4 : 1 << size;
            logic [31:0] exp = exp_word(addr, n);
            logic [31:0] got_data;
            int lat = kind == 2 ? n + 1 : n + 2;
            int cyc = 0;
            bit got = 0;
            bit bad = 0;
            if (kind == 2) for (int i = 0; i < 4; i++) exp[8*i +: 8] = i < n ? data[8*i +: 8] : 8'h00;
            if (kind == 0) begin
                if_en = 1'b1; if_pc = addr;
            end else begin
                lsb_en = 1'b1; lsb_wr = (kind == 2); lsb_addr = addr; lsb_size = size; lsb_w_data = data;
            end
            while (!got && cyc < 20) begin
                @(negedge clk);
                cyc++;
                if ((kind != 2 && mem_wr) || (kind == 0 ? lsb_done : if_done)) bad = 1;
                got = kind == 0 ? if_done : lsb_done;
            end
            if_en = 1'b0; lsb_en = 1'b0; lsb_wr = 1'b0;
            checks++;
            if (!got || cyc != lat || bad) begin
                errors++;
                $display("FAIL rand%0d_timing: kind=%0d n=%0d done=%b cycle %0d stray=%b expected cycle %0d",
                         t, kind, n, got, cyc, bad, lat);
            end
            got_data = kind == 0 ? if_data : kind == 1 ? lsb_r_data : exp_word(addr, n);
            checks++;
            if (got_data !== exp) begin
                errors++;
                $display("FAIL rand%0d_data: kind=%0d addr=%h n=%0d got %h expected %h", t, kind, addr, n, got_data, exp);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid_read;
        int cyc = 0;
        bit got = 0;
        logic [31:0] exp = exp_word(32'h104, 4);
        if_en = 1'b1; if_pc = 32'h100;
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({mem_a, mem_dout, mem_wr, if_done, lsb_done, if_data, lsb_r_data} !== '0) begin
            errors++;
            $display("FAIL async_reset: mem_a=%h dout=%h wr=%b if_data=%h r_data=%h expected all 0",
                     mem_a, mem_dout, mem_wr, if_data, lsb_r_data);
        end
        if_en = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        if_en = 1'b1; if_pc = 32'h104;
        while (!got && cyc < 20) begin
            @(negedge clk);
            cyc++;
            got = if_done;
        end
        if_en = 1'b0;
        checks++;
        if (!got || cyc != 6 || if_data !== exp) begin
            errors++;
            $display("FAIL post_reset_fetch: done=%b cycle %0d data=%h expected cycle 6 %h", got, cyc, if_data, exp);
        end
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; rdy = 1'b1; rollback = 1'b0; io_buffer_full = 1'b0; mem_din = 8'h00;
        if_en = 1'b0; if_pc = '0;
        lsb_en = 1'b0; lsb_wr = 1'b0; lsb_addr = '0; lsb_size = 2'd0; lsb_w_data = '0;
        test_reset;
        test_fetch;
        test_half_load;
        test_word_store;
        test_contention_rollback;
        test_io;
        test_rdy;
        test_wrap;
        test_random;
        test_reset_mid_read;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
